mem_stage_sram: RTL and testbench
=================================

Name: mem_stage_sram

Overview:
- MEM stage of the 5-stage pipeline, directly downstream of the EXE/MEM register.
- Takes a load/store from the EXE/MEM register and performs a multi-cycle word access to an external single-port SRAM under a wait-state FSM.
- Raises a freeze to IF/ID/EXE while the access is in progress.
- Contains the MEM/WB pipeline register that feeds write-back.

Parameters:
- DATA_W, 32, data and address width.
- ADDR_W, 16, SRAM word-address width; SRAM depth is 2^ADDR_W words.
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.
- WAIT_CYCLES, 4, SRAM access cycles per transfer; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_en_in  in  1  write-back enable from EXE/MEM register
- mem_signal_in  in  2  bit1 = MEM_R_EN (load), bit0 = MEM_W_EN (store)
- dest_in  in  5  destination register
- pc_in  in  DATA_W  instruction PC
- alu_result_in  in  DATA_W  ALU result; byte address for a load/store
- reg2_in  in  DATA_W  store data
- freeze  out  1  combinational; holds IF/ID/EXE registers and the PC
- sram_addr  out  ADDR_W  SRAM word address
- sram_wdata  out  DATA_W  SRAM write data
- sram_we_n  out  1  SRAM write strobe, active-low
- sram_oe_n  out  1  SRAM output enable, active-low
- sram_rdata  in  DATA_W  SRAM read data
- wb_en_out  out  1  MEM/WB register: write-back enable
- mem_r_en_out  out  1  MEM/WB register: selects mem_data_out for write-back
- dest_out  out  5  MEM/WB register: destination register
- pc_out  out  DATA_W  MEM/WB register: PC
- alu_result_out  out  DATA_W  MEM/WB register: ALU result
- mem_data_out  out  DATA_W  MEM/WB register: load data

Behaviour:
- Reset:
  - State goes to IDLE; counter = 0; read-data latch = 0.
  - All MEM/WB outputs = 0.
  - freeze = 0, sram_we_n = 1, sram_oe_n = 1.
  - sram_addr = 0 and sram_wdata = 0 while IDLE.
- Address decode:
  - word = (alu_result_in - BASE_ADDR) >> 2; bits [1:0] are ignored.
  - in_range = (alu_result_in >= BASE_ADDR) and word < 2^ADDR_W.
  - sram_addr = word[ADDR_W-1:0]; sram_wdata = reg2_in.
- mem_signal_in = 2'b11 is illegal: treat it as a load and suppress the write.
- FSM states:
  - IDLE:
    - If mem_signal_in is nonzero: freeze = 1, go to ACCESS, counter = 0.
    - Otherwise: freeze = 0; MEM/WB captures the inputs at the edge; mem_data_out = 0.
  - ACCESS:
    - freeze = 1.
    - Load: sram_oe_n = 0. Store: sram_we_n = !in_range.
    - counter increments each cycle.
    - At counter == WAIT_CYCLES-1, latch sram_rdata (or 0 if !in_range) and go to DONE.
  - DONE:
    - freeze = 0; strobes are high (inactive).
    - MEM/WB captures the inputs, with mem_data_out taken from the latch.
    - Go to IDLE.
- Inputs stay stable throughout IDLE-detect, ACCESS and DONE, because freeze holds the EXE/MEM source.
- MEM/WB register:
  - While freeze = 1, it loads a bubble: wb_en_out = 0, mem_r_en_out = 0, other fields unchanged.
  - A bubble is never written back twice.
- Timing per memory op:
  - freeze is high for WAIT_CYCLES+1 cycles (detect cycle plus ACCESS cycles).
  - The stage is occupied for WAIT_CYCLES+2 cycles in total.
  - Results appear on the MEM/WB outputs the cycle after DONE.
- Non-memory instruction: 1-cycle passthrough, freeze = 0.
- Back-to-back memory ops: the DONE edge advances EXE/MEM, so the next op is detected in the following IDLE cycle. There is no overlap.
- Out-of-range access:
  - Full latency is still taken.
  - A load returns 0; a store never drives sram_we_n low.
- Store with wb_en_in = 1: passes through as given; this stage does not override it.
- Reset asserted mid-ACCESS:
  - The access is abandoned.
  - sram_we_n and sram_oe_n are high in the cycle after the reset edge.
  - The latch is cleared and freeze drops.

Test Plan:
- Store: alu_result_in = 1028, reg2_in = 0xDEADBEEF, mem_signal_in = 01, WAIT_CYCLES = 4 -> freeze high 5 cycles; sram_addr = 1; sram_we_n low exactly 4 cycles; wb_en_out stays 0.
- Load: alu_result_in = 1028, mem_signal_in = 10, wb_en_in = 1, dest_in = 7, SRAM model holds 0xDEADBEEF -> freeze high 5 cycles; then wb_en_out = 1, mem_r_en_out = 1, dest_out = 7, mem_data_out = 0xDEADBEEF for one capture.
- ALU op: mem_signal_in = 00, alu_result_in = 0x55, dest_in = 3 -> freeze never high; next cycle alu_result_out = 0x55, dest_out = 3, mem_data_out = 0.
- Out-of-range: load at 0x10 -> mem_data_out = 0, latency still 5 freeze cycles. Store at 0x10 -> sram_we_n never low.
- Reset in 3rd ACCESS cycle of a store -> next cycle sram_we_n = 1, freeze = 0, all MEM/WB outputs 0, state IDLE. A following load completes normally.
- Back-to-back: load then ALU op -> the ALU result appears on MEM/WB exactly 1 cycle after the load result. The load bubble cycles show wb_en_out = 0.

Source files
------------

// File: rtl/mem_stage_sram.sv
// ============================================================================
//  mem_stage_sram
//  MEM stage: multi-cycle single-port SRAM access with pipeline freeze and
//  MEM/WB register.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage_sram #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic [1:0]        mem_signal_in,
  input  logic [4:0]        dest_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] reg2_in,
  output logic              freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [4:0]        dest_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] mem_data_out
);

  localparam int                CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [DATA_W-1:0] BASE     = DATA_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               wb_en_q;
  logic               mem_r_en_q;
  logic [4:0]         dest_q;
  logic [DATA_W-1:0]  pc_q;
  logic [DATA_W-1:0]  alu_q;
  logic [DATA_W-1:0]  mem_data_q;

  logic [DATA_W-1:0]  w_offset;
  logic [DATA_W-1:0]  w_word;
  logic               w_in_range;
  logic               w_mem_op;
  logic               w_is_load;
  logic               w_is_store;

  // Encoding 2'b11 is treated as a load with the write suppressed.
  assign w_mem_op   = |mem_signal_in;
  assign w_is_load  = mem_signal_in[1];
  assign w_is_store = (mem_signal_in == 2'b01);

  assign w_offset   = alu_result_in - BASE;
  assign w_word     = w_offset >> 2;
  assign w_in_range = (alu_result_in >= BASE) && ((w_word >> ADDR_W) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    freeze     = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (w_mem_op) begin
          freeze  = 1'b1;
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        freeze     = 1'b1;
        sram_addr  = w_word[ADDR_W-1:0];
        sram_wdata = reg2_in;
        sram_oe_n  = !w_is_load;
        sram_we_n  = !(w_is_store && w_in_range);
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          rdata_d = w_in_range ? sram_rdata : '0;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        sram_addr  = w_word[ADDR_W-1:0];
        sram_wdata = reg2_in;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // While frozen only the enables are cleared so a bubble cannot write back.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      dest_q     <= '0;
      pc_q       <= '0;
      alu_q      <= '0;
      mem_data_q <= '0;
    end else if (freeze) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
    end else begin
      wb_en_q    <= wb_en_in;
      mem_r_en_q <= mem_signal_in[1];
      dest_q     <= dest_in;
      pc_q       <= pc_in;
      alu_q      <= alu_result_in;
      mem_data_q <= (state_q == S_DONE) ? rdata_q : '0;
    end
  end

  assign wb_en_out      = wb_en_q;
  assign mem_r_en_out   = mem_r_en_q;
  assign dest_out       = dest_q;
  assign pc_out         = pc_q;
  assign alu_result_out = alu_q;
  assign mem_data_out   = mem_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_sram.sv
// ============================================================================
//  tb_mem_stage_sram
//  Randomized bench for mem_stage_sram against a transaction-level model.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_stage_sram;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 16;
  localparam int BASE_ADDR   = 1024;
  localparam int WAIT_CYCLES = 4;
  localparam int NWORDS      = 65536;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wb_en_in = 1'b0;
  logic [1:0]        mem_signal_in = 2'b00;
  logic [4:0]        dest_in = '0;
  logic [DATA_W-1:0] pc_in = '0;
  logic [DATA_W-1:0] alu_result_in = '0;
  logic [DATA_W-1:0] reg2_in = '0;
  logic              freeze;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic [DATA_W-1:0] sram_rdata;
  logic              wb_en_out;
  logic              mem_r_en_out;
  logic [4:0]        dest_out;
  logic [DATA_W-1:0] pc_out;
  logic [DATA_W-1:0] alu_result_out;
  logic [DATA_W-1:0] mem_data_out;

  mem_stage_sram #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_signal_in(mem_signal_in),
    .dest_in(dest_in), .pc_in(pc_in), .alu_result_in(alu_result_in), .reg2_in(reg2_in),
    .freeze(freeze), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_rdata(sram_rdata),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .dest_out(dest_out),
    .pc_out(pc_out), .alu_result_out(alu_result_out), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // External SRAM device: asynchronous read, write on a clock edge while we_n low.
  logic [DATA_W-1:0] dev_mem [0:NWORDS-1];
  logic [DATA_W-1:0] ref_mem [0:NWORDS-1];
  always @(posedge clk) if (!sram_we_n) dev_mem[sram_addr] <= sram_wdata;
  assign sram_rdata = dev_mem[sram_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: current instruction, cycle index within it, expected outputs.
  logic              c_wb;
  logic [1:0]        c_ms;
  logic [4:0]        c_dest;
  logic [31:0]       c_pc, c_alu, c_r2;
  logic              c_inr;
  logic [15:0]       c_word;
  int                k, occ;

  logic              chk_en = 1'b0;
  logic              chk_md = 1'b1;
  logic              e_freeze = 1'b0, e_we_n = 1'b1, e_oe_n = 1'b1;
  logic [15:0]       e_addr = '0;
  logic [31:0]       e_wdata = '0;
  logic              e_wb = 1'b0, e_mr = 1'b0;
  logic [4:0]        e_dest = '0;
  logic [31:0]       e_pc = '0, e_alu = '0, e_md = '0;

  int                cnt_freeze = 0, cnt_we_low = 0;
  logic [15:0]       last_we_addr = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("freeze", 32'(freeze), 32'(e_freeze));
      chk("sram_we_n", 32'(sram_we_n), 32'(e_we_n));
      chk("sram_oe_n", 32'(sram_oe_n), 32'(e_oe_n));
      chk("sram_addr", 32'(sram_addr), 32'(e_addr));
      chk("sram_wdata", sram_wdata, e_wdata);
      chk("wb_en_out", 32'(wb_en_out), 32'(e_wb));
      chk("mem_r_en_out", 32'(mem_r_en_out), 32'(e_mr));
      chk("dest_out", 32'(dest_out), 32'(e_dest));
      chk("pc_out", pc_out, e_pc);
      chk("alu_result_out", alu_result_out, e_alu);
      if (chk_md) chk("mem_data_out", mem_data_out, e_md);
      if (freeze) cnt_freeze++;
      if (!sram_we_n) begin
        cnt_we_low++;
        last_we_addr = sram_addr;
      end
    end
  end

  task automatic set_comb();
    logic mem, ld, st, acc;
    mem = (c_ms != 2'b00);
    ld  = c_ms[1];
    st  = (c_ms == 2'b01);
    acc = mem && (k >= 1) && (k <= WAIT_CYCLES);
    e_freeze = mem && (k <= WAIT_CYCLES);
    e_oe_n   = !(acc && ld);
    e_we_n   = !(acc && st && c_inr);
    e_addr   = (mem && k >= 1) ? c_word : 16'h0;
    e_wdata  = (mem && k >= 1) ? c_r2 : 32'h0;
  endtask

  task automatic step();
    set_comb();
    @(posedge clk); #1;
    if (k < occ - 1) begin
      e_wb = 1'b0;
      e_mr = 1'b0;
    end else begin
      e_wb   = c_wb;
      e_mr   = c_ms[1];
      e_dest = c_dest;
      e_pc   = c_pc;
      e_alu  = c_alu;
      if (c_ms == 2'b00) begin
        e_md = 32'h0; chk_md = 1'b1;
      end else if (c_ms[1]) begin
        e_md = c_inr ? ref_mem[c_word] : 32'h0; chk_md = 1'b1;
      end else begin
        if (c_inr) ref_mem[c_word] = c_r2;
        chk_md = 1'b0;
      end
    end
    k++;
  endtask

  task automatic load_instr(input logic wb, input logic [1:0] ms, input logic [4:0] dest,
                            input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] r2);
    logic [31:0] off;
    wb_en_in = wb; mem_signal_in = ms; dest_in = dest;
    pc_in = pc; alu_result_in = alu; reg2_in = r2;
    c_wb = wb; c_ms = ms; c_dest = dest; c_pc = pc; c_alu = alu; c_r2 = r2;
    off    = alu - 32'(BASE_ADDR);
    c_inr  = (alu >= 32'(BASE_ADDR)) && ((off / 4) < 32'(NWORDS));
    c_word = off[17:2];
    occ    = (ms != 2'b00) ? WAIT_CYCLES + 2 : 1;
    k      = 0;
  endtask

  task automatic issue(input logic wb, input logic [1:0] ms, input logic [4:0] dest,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] r2);
    load_instr(wb, ms, dest, pc, alu, r2);
    repeat (occ) step();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h10;
      1:       return 32'(BASE_ADDR) + 32'(4 * NWORDS) + 32'($urandom_range(0, 15));
      2:       return 32'hFFFF_FFF0;
      3:       return 32'(BASE_ADDR) + 32'(4 * (NWORDS - 1));
      default: return 32'(BASE_ADDR) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      dev_mem[i] = '0;
      ref_mem[i] = '0;
    end
    c_wb = 0; c_ms = 0; c_dest = 0; c_pc = 0; c_alu = 0; c_r2 = 0;
    c_inr = 0; c_word = 0; k = 0; occ = 1;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    issue(0, 2'b00, 0, 0, 0, 0);

    // Store 0xDEADBEEF to byte 1028 (word 1).
    cnt_freeze = 0; cnt_we_low = 0;
    issue(0, 2'b01, 5'd9, 32'h100, 32'd1028, 32'hDEADBEEF);
    chk("store freeze cycles", 32'(cnt_freeze), 32'd5);
    chk("store we_n low cycles", 32'(cnt_we_low), 32'd4);
    chk("store sram word", 32'(last_we_addr), 32'd1);
    chk("store wb_en_out", 32'(wb_en_out), 32'd0);

    // Load back, immediately followed by an ALU op.
    cnt_freeze = 0;
    issue(1, 2'b10, 5'd7, 32'h104, 32'd1028, 32'h0);
    chk("load freeze cycles", 32'(cnt_freeze), 32'd5);
    chk("load wb_en_out", 32'(wb_en_out), 32'd1);
    chk("load mem_r_en_out", 32'(mem_r_en_out), 32'd1);
    chk("load dest_out", 32'(dest_out), 32'd7);
    chk("load mem_data_out", mem_data_out, 32'hDEADBEEF);
    cnt_freeze = 0;
    issue(1, 2'b00, 5'd3, 32'h108, 32'h55, 32'h0);
    chk("alu freeze cycles", 32'(cnt_freeze), 32'd0);
    chk("alu alu_result_out", alu_result_out, 32'h55);
    chk("alu dest_out", 32'(dest_out), 32'd3);
    chk("alu mem_data_out", mem_data_out, 32'h0);

    // Out-of-range load and store at byte 0x10.
    cnt_freeze = 0;
    issue(1, 2'b10, 5'd4, 32'h10C, 32'h10, 32'h0);
    chk("oor load freeze cycles", 32'(cnt_freeze), 32'd5);
    chk("oor load mem_data_out", mem_data_out, 32'h0);
    cnt_we_low = 0;
    issue(0, 2'b01, 5'd4, 32'h110, 32'h10, 32'h12345678);
    chk("oor store we_n low cycles", 32'(cnt_we_low), 32'd0);

    // Reset during the third ACCESS cycle of a store to word 2.
    load_instr(0, 2'b01, 5'd1, 32'h114, 32'd1032, 32'hCAFEF00D);
    repeat (3) step();
    set_comb();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    // The SRAM saw write strobes before the abort, so word 2 holds the data.
    ref_mem[c_word] = c_r2;
    e_wb = 0; e_mr = 0; e_dest = 0; e_pc = 0; e_alu = 0; e_md = 0; chk_md = 1'b1;
    issue(0, 2'b00, 0, 0, 0, 0);
    chk("post-reset freeze", 32'(freeze), 32'd0);
    cnt_freeze = 0;
    issue(1, 2'b10, 5'd12, 32'h118, 32'd1028, 32'h0);
    chk("post-reset load freeze cycles", 32'(cnt_freeze), 32'd5);
    chk("post-reset load data", mem_data_out, 32'hDEADBEEF);

    for (int n = 0; n < 200; n++) begin
      logic [1:0] ms;
      ms = 2'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), ms, 5'($urandom_range(0, 31)), $urandom(),
            (ms == 2'b00) ? $urandom() : rand_addr(), $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
